instr_block_memory: RTL and testbench

//  Parametrised instruction memory; successor to the fixed 1 KiB, 16-byte-block, #40-delay memory.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/instr_block_memory.sv | 122 ++++++++++++
 tb/tb_instr_block_memory.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction memory and its dmem/cache siblings.
//   imem_state_t : access FSM encoding (IDLE, BUSY, DONE)
//   clog2        : ceiling log2 for deriving address/counter widths
// ---------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } imem_state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int p = 1; p < value; p = p * 2) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_block_memory.sv
// ---------------------------------------------------------------------------
// instr_block_memory
// Parametrised block-read instruction memory behind the instruction cache.
// A request is accepted on a clock edge, and a whole BLOCK_BYTES block is
// returned READ_LATENCY edges later with a one-cycle rvalid pulse.
// A separate byte-wide port loads the program image.
//
// Ports
//   clock      : single clock, all state changes on posedge
//   reset      : asynchronous, active-low
//   read       : block read request (level, held until busywait falls)
//   address    : block address
//   readinst   : block data, byte k at bits [8k+7:8k]
//   busywait   : high while an access is pending
//   rvalid     : one-cycle pulse when readinst is updated
//   prog_we    : program-load byte write enable
//   prog_addr  : program-load byte address
//   prog_data  : program-load byte
// ---------------------------------------------------------------------------
module instr_block_memory
    import imem_pkg::*;
#(
    parameter int    BLOCK_BYTES  = 16,
    parameter int    BLOCK_ADDR_W = 6,
    parameter int    READ_LATENCY = 5,
    parameter string INIT_FILE    = ""
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        read,
    input  logic [BLOCK_ADDR_W-1:0]                     address,
    output logic [8*BLOCK_BYTES-1:0]                    readinst,
    output logic                                        busywait,
    output logic                                        rvalid,
    input  logic                                        prog_we,
    input  logic [BLOCK_ADDR_W+clog2(BLOCK_BYTES)-1:0]  prog_addr,
    input  logic [7:0]                                  prog_data
);

    localparam int OFF_W       = clog2(BLOCK_BYTES);
    localparam int BYTE_ADDR_W = BLOCK_ADDR_W + OFF_W;
    localparam int DEPTH       = BLOCK_BYTES << BLOCK_ADDR_W;
    localparam int CNT_W       = (READ_LATENCY > 1) ? clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    logic [7:0]              mem [0:DEPTH-1];
    imem_state_t             state;
    logic [CNT_W-1:0]        count;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [8*BLOCK_BYTES-1:0] block_data;

    // Program-load port; the array is never reset so a reset keeps the image.
    always @(posedge clock) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Gather the addressed block, byte k from {addr_q, k}.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_gather
            logic [BYTE_ADDR_W-1:0] byte_idx;
            assign byte_idx = {addr_q, OFF_W'(gi)};
            assign block_data[8*gi +: 8] = mem[byte_idx];
        end
    endgenerate

    // An access only counts as pending while the request is still held, so
    // dropping read aborts and releases busywait in the same cycle.
    assign busywait = reset & read &
                      ((state == IDLE) | (state == BUSY) | (state == DONE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            addr_q   <= '0;
            readinst <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (read) begin
                        addr_q <= address;
                        count  <= CNT_LOAD;
                        state  <= (READ_LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (!read) begin
                        state <= IDLE;
                    end else if (address != addr_q) begin
                        // Restart: the new address gets the full latency.
                        addr_q <= address;
                        count  <= CNT_LOAD;
                    end else if (count == CNT_W'(1)) begin
                        // Last BUSY edge; DONE's edge is the one that loads data.
                        count <= '0;
                        state <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (read) begin
                        // Same-edge program writes land after this sample.
                        readinst <= block_data;
                        rvalid   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_read_known: assert property (@(posedge clock) disable iff (!reset)
        (state == IDLE) |-> !$isunknown(read));

endmodule

// File: tb/tb_instr_block_memory.sv
// ---------------------------------------------------------------------------
// tb_instr_block_memory
// Directed bench for instr_block_memory: a default-parameter instance (dut_a)
// and a BLOCK_BYTES=4 / READ_LATENCY=1 instance (dut_b).
// ---------------------------------------------------------------------------
module tb_instr_block_memory;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // Default instance
    logic         a_read = 1'b0;
    logic [5:0]   a_address = '0;
    logic [127:0] a_readinst;
    logic         a_busywait;
    logic         a_rvalid;
    logic         a_prog_we = 1'b0;
    logic [9:0]   a_prog_addr = '0;
    logic [7:0]   a_prog_data = '0;

    // Short-block, single-cycle instance
    logic         b_read = 1'b0;
    logic [1:0]   b_address = '0;
    logic [31:0]  b_readinst;
    logic         b_busywait;
    logic         b_rvalid;
    logic         b_prog_we = 1'b0;
    logic [3:0]   b_prog_addr = '0;
    logic [7:0]   b_prog_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] BLK0     = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK0_EE  = 128'h0F0E0D0C0B0A090807060504EE020100;
    localparam logic [127:0] BLK5     = 128'h5F5E5D5C5B5A59585756555453525150;

    instr_block_memory #(
        .BLOCK_BYTES(16), .BLOCK_ADDR_W(6), .READ_LATENCY(5), .INIT_FILE("")
    ) dut_a (
        .clock(clock), .reset(reset), .read(a_read), .address(a_address),
        .readinst(a_readinst), .busywait(a_busywait), .rvalid(a_rvalid),
        .prog_we(a_prog_we), .prog_addr(a_prog_addr), .prog_data(a_prog_data)
    );

    instr_block_memory #(
        .BLOCK_BYTES(4), .BLOCK_ADDR_W(2), .READ_LATENCY(1), .INIT_FILE("")
    ) dut_b (
        .clock(clock), .reset(reset), .read(b_read), .address(b_address),
        .readinst(b_readinst), .busywait(b_busywait), .rvalid(b_rvalid),
        .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_data(b_prog_data)
    );

    always #5 clock = ~clock;

    // Memory image of dut_a: byte i holds i, so block n byte k is n*16+k.
    function automatic logic [127:0] blk(input int n);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(n * 16 + k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int pulses;
        int first_e;
        int second_e;

        // ---- Reset state ----
        #2 reset = 1'b0;
        #1;
        chk("rst_a_busy", 128'(a_busywait), 128'd0);
        chk("rst_a_rvalid", 128'(a_rvalid), 128'd0);
        chk("rst_a_data", a_readinst, 128'd0);
        chk("rst_b_data", 128'(b_readinst), 128'd0);
        tick();
        #3 reset = 1'b1;

        // ---- Program load: dut_a bytes 0..111 = i, dut_b bytes 0..15 = C0+i ----
        tick();
        for (int i = 0; i < 112; i++) begin
            a_prog_we   = 1'b1;
            a_prog_addr = 10'(i);
            a_prog_data = 8'(i);
            b_prog_we   = (i < 16);
            b_prog_addr = 4'(i);
            b_prog_data = 8'(8'hC0 + i);
            tick();
        end
        a_prog_we = 1'b0;
        b_prog_we = 1'b0;

        // ---- 1: basic read of block 0, latency 5 ----
        a_read = 1'b1; a_address = 6'd0;
        #1;
        chk("t1_busy_same_cycle", 128'(a_busywait), 128'd1);
        tick();                                  // edge 0
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("t1_no_rvalid_early", 128'(a_rvalid), 128'd0);
        end
        chk("t1_data_not_yet", a_readinst, 128'd0);
        tick();                                  // edge 5
        a_read = 1'b0;
        #1;
        chk("t1_data", a_readinst, BLK0);
        chk("t1_rvalid", 128'(a_rvalid), 128'd1);
        chk("t1_busy_low", 128'(a_busywait), 128'd0);
        tick();
        chk("t1_rvalid_one_cycle", 128'(a_rvalid), 128'd0);

        // ---- 2: BLOCK_BYTES=4, READ_LATENCY=1, block 3 ----
        b_read = 1'b1; b_address = 2'd3;
        #1;
        chk("t2_busy", 128'(b_busywait), 128'd1);
        tick();                                  // edge 0
        chk("t2_rvalid_edge0", 128'(b_rvalid), 128'd0);
        tick();                                  // edge 1
        b_read = 1'b0;
        #1;
        chk("t2_data", 128'(b_readinst), 128'(32'hCFCECDCC));
        chk("t2_rvalid", 128'(b_rvalid), 128'd1);
        tick();
        chk("t2_rvalid_once", 128'(b_rvalid), 128'd0);

        // ---- 3: abort on block 2 after edge 2 ----
        a_read = 1'b1; a_address = 6'd2;
        tick(); tick(); tick();                  // edges 0,1,2
        a_read = 1'b0;
        #1;
        chk("t3_busy_drop", 128'(a_busywait), 128'd0);
        pulses = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (a_rvalid) pulses++;
        end
        chk("t3_no_rvalid", 128'(pulses), 128'd0);
        chk("t3_data_held", a_readinst, BLK0);
        a_read = 1'b1; a_address = 6'd2;
        tick();                                  // edge 0
        for (int e = 1; e <= 4; e++) tick();
        chk("t3_rvalid_not_at_4", 128'(a_rvalid), 128'd0);
        tick();                                  // edge 5
        a_read = 1'b0;
        #1;
        chk("t3_reread_data", a_readinst, blk(2));
        chk("t3_reread_rvalid", 128'(a_rvalid), 128'd1);
        tick();

        // ---- 4: restart from block 1 to block 5 at edge 3 ----
        a_read = 1'b1; a_address = 6'd1;
        pulses = 0;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e == 2) a_address = 6'd5;
            if (a_rvalid) pulses++;
            if (a_readinst === blk(1)) pulses = pulses + 100;
        end
        chk("t4_nothing_before_8", 128'(pulses), 128'd0);
        tick();                                  // edge 8
        a_read = 1'b0;
        #1;
        chk("t4_data_blk5", a_readinst, BLK5);
        chk("t4_rvalid", 128'(a_rvalid), 128'd1);
        tick();

        // ---- 5: back-to-back, blocks 4 then 6 ----
        a_read = 1'b1; a_address = 6'd4;
        pulses = 0; first_e = -1; second_e = -1;
        for (int e = 0; e <= 11; e++) begin
            tick();
            if (a_rvalid) begin
                pulses++;
                if (first_e < 0) begin
                    first_e = e;
                    chk("t5_first_data", a_readinst, blk(4));
                    a_address = 6'd6;
                    #1;
                    chk("t5_busy_reasserted", 128'(a_busywait), 128'd1);
                end else begin
                    second_e = e;
                end
            end
        end
        a_read = 1'b0;
        chk("t5_pulses", 128'(pulses), 128'd2);
        chk("t5_first_edge", 128'(first_e), 128'd5);
        chk("t5_second_edge", 128'(second_e), 128'd11);
        chk("t5_second_data", a_readinst, blk(6));
        tick();

        // ---- 6: asynchronous reset mid-BUSY ----
        a_read = 1'b1; a_address = 6'd3;
        tick(); tick();                          // edges 0,1
        #3 reset = 1'b0;
        #1;
        chk("t6_busy_rst", 128'(a_busywait), 128'd0);
        chk("t6_rvalid_rst", 128'(a_rvalid), 128'd0);
        chk("t6_data_rst", a_readinst, 128'd0);
        a_read = 1'b0;
        tick(); tick();
        #3 reset = 1'b1;
        tick();
        a_read = 1'b1; a_address = 6'd0;
        for (int e = 0; e <= 4; e++) tick();     // edges 0..4
        // Write byte 3 on the very edge that loads the block.
        a_prog_we = 1'b1; a_prog_addr = 10'd3; a_prog_data = 8'hEE;
        tick();                                  // edge 5
        a_prog_we = 1'b0;
        a_read = 1'b0;
        #1;
        chk("t6_mem_intact", a_readinst, BLK0);
        chk("t6_rvalid", 128'(a_rvalid), 128'd1);
        tick();

        // ---- Read-before-write result now visible ----
        a_read = 1'b1; a_address = 6'd0;
        for (int e = 0; e <= 5; e++) tick();
        a_read = 1'b0;
        #1;
        chk("rbw_new_data", a_readinst, BLK0_EE);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
